// File: rtl/io_bus_if.sv
// io_bus_if: CPU-side IO bus between the pipelined CPU (master) and the
// IO responder (slave). Writes are qualified by io_we for one cycle; read
// data io_din is a combinational function of io_addr.
interface io_bus_if;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic [31:0] io_din;

  // CPU side: drives address, write data and write enable.
  modport master (
    output io_addr,
    output io_dout,
    output io_we,
    input  io_din
  );

  // Responder side: decodes the bus and returns read data.
  modport slave (
    input  io_addr,
    input  io_dout,
    input  io_we,
    output io_din
  );
endinterface

// File: rtl/io_bus_responder.sv
// io_bus_responder: memory-mapped IO responder for the CPU IO bus.
//  - 0x00 LED register (5 bits), 0x0C display register (8 hex digits),
//    0x10 input valid flag (write = ack), 0x14 committed input word,
//    0x18 live entry shift buffer.
//  - Pushbutton 'valid' is synchronised (2 FF), optionally debounced, and
//    edge detected; each event either shifts in a hex digit or commits the
//    buffer into the input word handed to the CPU.
//  - The display register is scanned one digit at a time onto an/seg.
// Build option: define DEBOUNCE_EN to require the synchronised valid level
// to be stable for DB_CYCLES cycles before it is accepted.
module io_bus_responder #(
  parameter int SCAN_DIV  = 16,
  parameter int DB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [4:0]  in,
  io_bus_if.slave     bus,
  output logic        ready,
  output logic [4:0]  out0,
  output logic [2:0]  an,
  output logic [3:0]  seg
);

  // Address map
  localparam logic [7:0] ADDR_LED   = 8'h00;
  localparam logic [7:0] ADDR_DISP  = 8'h0C;
  localparam logic [7:0] ADDR_VLD   = 8'h10;
  localparam logic [7:0] ADDR_DATA  = 8'h14;
  localparam logic [7:0] ADDR_SHIFT = 8'h18;

`ifdef DEBOUNCE_EN
  localparam bit DB_ON = 1'b1;
`else
  localparam bit DB_ON = 1'b0;
`endif

  // Scan divider sizing
  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Architectural registers
  logic [4:0]       r_out0;
  logic [31:0]      r_disp;
  logic [31:0]      r_shift;
  logic [31:0]      r_in_data;
  logic             r_in_vld;
  logic [2:0]       r_an;
  logic [3:0]       r_seg;
  logic [DIV_W-1:0] r_div;

  // Input conditioning
  logic [1:0]       r_sync;
  logic             r_level_d;
  logic             w_sync;
  logic             w_level;
  logic             w_evt;

  // Bus decode
  logic             w_wr_led;
  logic             w_wr_disp;
  logic             w_ack;
  logic             w_vld_eff;
  logic             w_entry;
  logic             w_commit;
  logic [31:0]      w_din;

  // Scan helpers
  logic             w_div_wrap;
  logic [2:0]       w_an_next;
  logic [3:0]       w_nib [8];

  // ------------------------------------------------------------------
  // valid synchroniser: two flops into the clk domain, reset to 0 so a
  // button held through reset yields exactly one rising edge afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], valid};
    end
  end

  assign w_sync = r_sync[1];

  // Optional debounce stage between synchroniser and edge detector.
  generate
    if (DB_ON) begin : g_debounce
      localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
      localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

      logic            r_db_level;
      logic [DB_W-1:0] r_db_cnt;

      // Level follows the synchronised input only after DB_CYCLES stable cycles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_db_level <= 1'b0;
          r_db_cnt   <= '0;
        end else if (w_sync != r_db_level) begin
          if (r_db_cnt == DB_LAST) begin
            r_db_level <= w_sync;
            r_db_cnt   <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end else begin
          r_db_cnt <= '0;
        end
      end

      assign w_level = r_db_level;
    end else begin : g_no_debounce
      assign w_level = w_sync;
    end
  endgenerate

  // Edge stage: remembers the previous conditioned level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= w_level;
    end
  end

  // One event per press: rising edge of the conditioned level.
  assign w_evt = w_level & ~r_level_d;

  // ------------------------------------------------------------------
  // Write decode. An ack in the same cycle as an event is applied first,
  // so the event sees the input word as already consumed.
  assign w_wr_led  = bus.io_we && (bus.io_addr == ADDR_LED);
  assign w_wr_disp = bus.io_we && (bus.io_addr == ADDR_DISP);
  assign w_ack     = bus.io_we && (bus.io_addr == ADDR_VLD);
  assign w_vld_eff = r_in_vld & ~w_ack;
  assign w_entry   = w_evt & ~w_vld_eff &  in[4];
  assign w_commit  = w_evt & ~w_vld_eff & ~in[4];

  // CPU-writable output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out0 <= 5'd0;
      r_disp <= 32'd0;
    end else begin
      if (w_wr_led) begin
        r_out0 <= bus.io_dout[4:0];
      end
      if (w_wr_disp) begin
        r_disp <= bus.io_dout;
      end
    end
  end

  // Entry buffer and handshake: digits shift in, commit publishes the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= 32'd0;
      r_in_data <= 32'd0;
      r_in_vld  <= 1'b0;
    end else begin
      if (w_ack) begin
        r_in_vld <= 1'b0;
      end
      if (w_entry) begin
        r_shift <= {r_shift[27:0], in[3:0]};
      end else if (w_commit) begin
        r_in_data <= r_shift;
        r_in_vld  <= 1'b1;
        r_shift   <= 32'd0;
      end
    end
  end

  // Read mux, combinational from the address.
  always_comb begin
    w_din = 32'd0;
    unique case (bus.io_addr)
      ADDR_LED:   w_din = {27'd0, r_out0};
      ADDR_DISP:  w_din = r_disp;
      ADDR_VLD:   w_din = {31'd0, r_in_vld};
      ADDR_DATA:  w_din = r_in_data;
      ADDR_SHIFT: w_din = r_shift;
      default:    w_din = 32'd0;
    endcase
  end

  assign bus.io_din = w_din;

  // ------------------------------------------------------------------
  // Display scan: split the display register into its eight nibbles.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_nib
      assign w_nib[gi] = r_disp[4*gi +: 4];
    end
  endgenerate

  assign w_div_wrap = (r_div == DIV_LAST);
  assign w_an_next  = w_div_wrap ? (r_an + 3'd1) : r_an;

  // Divider and digit index; seg is registered alongside an so both move
  // on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_an  <= 3'd0;
      r_seg <= 4'd0;
    end else begin
      r_div <= w_div_wrap ? '0 : (r_div + 1'b1);
      r_an  <= w_an_next;
      r_seg <= w_nib[w_an_next];
    end
  end

  // ------------------------------------------------------------------
  assign ready = ~r_in_vld;
  assign out0  = r_out0;
  assign an    = r_an;
  assign seg   = r_seg;

endmodule

// File: tb/tb_io_bus_responder.sv
// Directed testbench for io_bus_responder: bus reads/writes, hex entry,
// commit/ack handshake, display scan and reset behaviour. Works with or
// without DEBOUNCE_EN defined.
module tb_io_bus_responder;
  localparam int SCAN_DIV  = 16;
  localparam int DB_CYCLES = 4;
`ifdef DEBOUNCE_EN
  localparam int EVT_LAT = 2 + DB_CYCLES + 1;
`else
  localparam int EVT_LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [4:0] in;
  logic       ready;
  logic [4:0] out0;
  logic [2:0] an;
  logic [3:0] seg;

  int tests = 0;
  int fails = 0;

  io_bus_if bus();

  io_bus_responder #(
    .SCAN_DIV (SCAN_DIV),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .valid(valid),
    .in   (in),
    .bus  (bus),
    .ready(ready),
    .out0 (out0),
    .an   (an),
    .seg  (seg)
  );

  always #5 clk = ~clk;

  // Move to 1ns after a rising edge (all stimulus is applied here).
  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Combinational read; result sampled 1ns after the address settles.
  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    bus.io_addr = a;
    #1;
    d = bus.io_din;
  endtask

  // One-cycle qualified write.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.io_addr = a;
    bus.io_dout = d;
    bus.io_we   = 1'b1;
    align();
    bus.io_we   = 1'b0;
  endtask

  // Full button press with release, long enough for debounce in both builds.
  task automatic press(input logic [4:0] v);
    in    = v;
    valid = 1'b1;
    repeat (EVT_LAT + 3) @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (EVT_LAT + 3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; valid = 1'b0; in = 5'd0;
    bus.io_addr = 8'h00; bus.io_dout = 32'd0; bus.io_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rd(8'h10, d); tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL reset_vld got=%h exp=%h", d, 32'd0); end
    rd(8'h14, d); tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL reset_data got=%h exp=%h", d, 32'd0); end
    rd(8'h00, d); tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL reset_led got=%h exp=%h", d, 32'd0); end
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", ready); end
    tests++;
    if (an !== 3'd0) begin fails++; $display("FAIL reset_an got=%0d exp=0", an); end
    tests++;
    if (seg !== 4'd0) begin fails++; $display("FAIL reset_seg got=%h exp=0", seg); end
    $display("[TB] reset: vld/data/led read, ready=%b an=%0d seg=%h", ready, an, seg);
  endtask

  task automatic test_entry();
    logic [31:0] d;
    press(5'h11); press(5'h12); press(5'h13); press(5'h1A);
    rd(8'h18, d); tests++;
    if (d !== 32'h0000123A) begin fails++; $display("FAIL entry_shift got=%h exp=%h", d, 32'h0000123A); end
    press(5'h00);
    align();
    rd(8'h14, d); tests++;
    if (d !== 32'h0000123A) begin fails++; $display("FAIL entry_data got=%h exp=%h", d, 32'h0000123A); end
    rd(8'h10, d); tests++;
    if (d !== 32'd1) begin fails++; $display("FAIL entry_vld got=%h exp=%h", d, 32'd1); end
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL entry_ready got=%b exp=0", ready); end
    rd(8'h18, d); tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL entry_shift_clr got=%h exp=%h", d, 32'd0); end
    align();
    wr(8'h10, 32'd0);
    rd(8'h10, d); tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL entry_ack got=%h exp=%h", d, 32'd0); end
    $display("[TB] entry: 1,2,3,A committed and acked");
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [3:0]  dig;
    for (int k = 1; k <= 9; k++) begin
      dig = 4'(k);
      press({1'b1, dig});
    end
    press(5'h00);
    align();
    rd(8'h14, d); tests++;
    if (d !== 32'h23456789) begin fails++; $display("FAIL ovf_data got=%h exp=%h", d, 32'h23456789); end
    press(5'h1F);
    align();
    rd(8'h18, d); tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL ovf_hold_shift got=%h exp=%h", d, 32'd0); end
    rd(8'h14, d); tests++;
    if (d !== 32'h23456789) begin fails++; $display("FAIL ovf_hold_data got=%h exp=%h", d, 32'h23456789); end
    align();
    wr(8'h10, 32'hFFFF_FFFF);
    rd(8'h10, d); tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL ovf_ack got=%h exp=%h", d, 32'd0); end
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL ovf_ready got=%b exp=1", ready); end
    $display("[TB] overflow: 9 digits committed, press while valid ignored, acked");
  endtask

  task automatic test_leds_scan();
    logic [31:0] d;
    logic [31:0] disp_val;
    logic [2:0]  prev;
    logic [2:0]  exp_an;
    bit          found;
    disp_val = 32'h89ABCDEF;
    wr(8'h0C, disp_val);
    wr(8'h00, 32'hFFFF_FFFF);
    rd(8'h00, d); tests++;
    if (d !== 32'h0000001F) begin fails++; $display("FAIL led_read got=%h exp=%h", d, 32'h1F); end
    tests++;
    if (out0 !== 5'h1F) begin fails++; $display("FAIL led_out0 got=%h exp=%h", out0, 5'h1F); end
    rd(8'h0C, d); tests++;
    if (d !== disp_val) begin fails++; $display("FAIL disp_read got=%h exp=%h", d, disp_val); end
    rd(8'h04, d); tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL unmapped_read got=%h exp=%h", d, 32'd0); end
    align(); align();
    // Wait for the scan to arrive at digit 0.
    found = 1'b0;
    prev  = an;
    for (int c = 0; c < 8 * SCAN_DIV + 4; c++) begin
      align();
      if (an == 3'd0 && prev != 3'd0) begin
        found = 1'b1;
        break;
      end
      prev = an;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL scan_timeout got=an%0d exp=an0", an);
    end else begin
      for (int k = 0; k <= 8; k++) begin
        exp_an = 3'(k % 8);
        tests++;
        if (an !== exp_an || seg !== disp_val[4*exp_an +: 4]) begin
          fails++;
          $display("FAIL scan_step got=an%0d/seg%h exp=an%0d/seg%h", an, seg, exp_an, disp_val[4*exp_an +: 4]);
        end
        $display("[TB] scan: an=%0d seg=%h", an, seg);
        if (k < 8) begin
          repeat (SCAN_DIV - 1) align();
          tests++;
          if (an !== exp_an) begin fails++; $display("FAIL scan_hold got=an%0d exp=an%0d", an, exp_an); end
          align();
        end
      end
    end
  endtask

  task automatic test_ack_commit_same_cycle();
    logic [31:0] d;
    press(5'h14);
    press(5'h00);
    align();
    rd(8'h14, d); tests++;
    if (d !== 32'h4) begin fails++; $display("FAIL same_pre_data got=%h exp=%h", d, 32'h4); end
    align();
    in    = 5'h00;
    valid = 1'b1;
    repeat (EVT_LAT - 1) @(posedge clk);
    #1;
    bus.io_addr = 8'h10;
    bus.io_we   = 1'b1;
    align();
    bus.io_we   = 1'b0;
    repeat (4) align();
    valid = 1'b0;
    repeat (EVT_LAT + 3) align();
    rd(8'h10, d); tests++;
    if (d !== 32'd1) begin fails++; $display("FAIL same_vld got=%h exp=%h", d, 32'd1); end
    rd(8'h14, d); tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL same_data got=%h exp=%h", d, 32'd0); end
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL same_ready got=%b exp=0", ready); end
    align();
    wr(8'h10, 32'd0);
    $display("[TB] ack+commit same cycle: in_vld held, in_data reloaded");
  endtask

  task automatic test_reset_hold();
    logic [31:0] d;
    press(5'h1C);
    rd(8'h18, d); tests++;
    if (d !== 32'hC) begin fails++; $display("FAIL hold_pre_shift got=%h exp=%h", d, 32'hC); end
    align();
    in    = 5'h15;
    valid = 1'b1;
    rst   = 1'b1;
    rd(8'h18, d); tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL hold_rst_shift got=%h exp=%h", d, 32'd0); end
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (EVT_LAT + 6) align();
    rd(8'h18, d); tests++;
    if (d !== 32'h5) begin fails++; $display("FAIL hold_one_event got=%h exp=%h", d, 32'h5); end
    rd(8'h0C, d); tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL hold_disp_clr got=%h exp=%h", d, 32'd0); end
    align();
    valid = 1'b0;
    repeat (EVT_LAT + 3) align();
    $display("[TB] reset with valid held: single event after release");
  endtask

  task automatic test_debounce_glitch();
`ifdef DEBOUNCE_EN
    logic [31:0] d;
    align();
    in    = 5'h17;
    valid = 1'b1;
    repeat (2) align();
    valid = 1'b0;
    repeat (EVT_LAT + 5) align();
    rd(8'h18, d); tests++;
    if (d !== 32'h5) begin fails++; $display("FAIL glitch_shift got=%h exp=%h", d, 32'h5); end
    $display("[TB] debounce: 2-cycle pulse rejected");
`endif
  endtask

  initial begin
    test_reset();
    test_entry();
    test_overflow();
    test_leds_scan();
    test_ack_commit_same_cycle();
    test_reset_hold();
    test_debounce_glitch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global bound so the run always ends on its own.
  initial begin
    #400000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/io_bus_responder.md
Name: io_bus_responder

Overview:
Memory-mapped IO-bus responder that services the CPU side of the IO_BUS (io_addr/io_dout/io_we/io_din). It latches CPU writes into the LED and 7-seg display registers. It assembles hex-digit switch entries into a 32-bit input word offered to the CPU under a valid/ack handshake. It also scans the display register onto the multiplexed digit outputs. It sits between the pipelined CPU and the board switches/LEDs/digits and runs on the CPU clock domain.

Parameters:
SCAN_DIV, 16, clk cycles each digit is held before the scan advances (>=2)
DB_CYCLES, 4, cycles valid must be stable before acceptance (DEBOUNCE_EN only)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
valid  in  1  pushbutton entry strobe, asynchronous to clk
in  in  5  in[4]=1: hex digit entry of in[3:0]; in[4]=0: commit
io_addr  in  8  CPU IO address (byte address, word aligned)
io_dout  in  32  CPU write data
io_we  in  1  CPU write enable, one-cycle qualified
io_din  out  32  read data to CPU, combinational from io_addr
ready  out  1  1 = input buffer empty, accepting entries
out0  out  5  LED register
an  out  3  current digit index 0..7
seg  out  4  hex nibble for digit an

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high. Reset clears every register: out0=0, disp=0, an=0, seg=0, shift buffer=0, in_data=0, in_vld=0, so ready=1 and io_din follows address decode of cleared registers.
- Address map, writes on io_we=1 at the clock edge: 0x00 → out0<=io_dout[4:0]; 0x0C → disp<=io_dout; 0x10 → ack, clears in_vld (data ignored). Writes to other addresses have no effect.
- Reads, combinational, zero latency: 0x00 → {27'b0,out0}; 0x0C → disp; 0x10 → {31'b0,in_vld}; 0x14 → in_data; 0x18 → shift buffer. Any other address → 0.
- valid passes through a 2-FF synchronizer followed by rising-edge detect. One accepted event per press; holding valid produces no repeats.
- Entry event with in[4]=1 and in_vld=0: buffer <= {buffer[27:0], in[3:0]}. After 8 digits the oldest nibble drops off the top.
- Commit event with in[4]=0 and in_vld=0: in_data<=buffer, in_vld<=1, buffer<=0.
- While in_vld=1, all entry and commit events are ignored; the buffer holds.
- ready = ~in_vld (registered state, no combinational path from valid).
- Same-cycle ack write and commit event: ack is applied first, so in_vld ends at 1 and in_data takes the new buffer value.
- Scan: a divider counts 0..SCAN_DIV-1. On wrap, an increments mod 8 (7→0). seg = disp[4*an+3 : 4*an], registered, so it updates on the same edge as an.
- Reset mid-entry or mid-handshake discards the partial buffer and any pending word. No spurious event is produced after reset release while valid is held high, because the synchronizer is reset to 0 and the first sampled high counts as a single edge.

Optional Feature:
DEBOUNCE_EN
- Defined: after synchronization, valid must stay at a new level for DB_CYCLES consecutive cycles before the debounced level changes. Edge detect operates on the debounced level, so glitches shorter than DB_CYCLES are ignored. Accept latency from valid rise is 2+DB_CYCLES+1 cycles.
- Undefined: no debounce; the event fires 3 cycles after valid rises (2 sync stages plus the edge stage).

Test Plan:
- Reset, then read 0x10, 0x14, 0x00 → 0, 0, 0; ready=1, an=0, seg=0.
- Press digits 1,2,3,A (in=5'h11,5'h12,5'h13,5'h1A), then commit (in=5'h00) → read 0x14=32'h0000123A, 0x10=1, ready=0; read 0x18=0.
- Enter 9 digits 1..9, commit → in_data=32'h23456789. While in_vld=1, an extra press of 5'h1F leaves 0x18=0. Write 0x10 → in_vld=0, ready=1.
- Write 0x0C=32'h89ABCDEF, 0x00=32'hFFFFFFFF → out0=5'h1F. Over 8*SCAN_DIV cycles an steps 0..7 with seg=F,E,D,C,B,A,9,8, then wraps to an=0.
- In the same cycle as a commit event, write 0x10 while in_vld=1 → in_vld stays 1 and in_data equals the new buffer.
- Hold valid high across reset assertion and release → exactly one event after release. With DEBOUNCE_EN, a 2-cycle valid pulse (DB_CYCLES=4) produces no event.
